// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the instruction and data caches.
// The dcache has fixed priority; a streak counter bounds how long the icache can be starved.
module mem_arbiter #(
    parameter int unsigned ISTARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready
);

    localparam logic [3:0] STREAK_MAX = 4'(ISTARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2,
        SETTLE = 2'd3
    } state_e;

    state_e     state_q;
    state_e     state_d;
    logic [3:0] streak_q;
    logic [3:0] streak_d;
    logic       d_req_s;

    assign d_req_s = dREN | dWEN;

    // Next-state and streak selection; requests are only sampled in IDLE.
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        case (state_q)
            IDLE: begin
                if (d_req_s && (!iREN || (streak_q < STREAK_MAX))) begin
                    state_d = DGRANT;
                    if (iREN) begin
                        if (streak_q < STREAK_MAX) begin
                            streak_d = streak_q + 4'd1;
                        end else begin
                            streak_d = streak_q;
                        end
                    end else begin
                        streak_d = 4'd0;
                    end
                end else if (iREN) begin
                    state_d  = IGRANT;
                    streak_d = 4'd0;
                end else begin
                    state_d  = IDLE;
                    streak_d = 4'd0;
                end
            end
            DGRANT: begin
                // ram_ready wins over a simultaneous request drop: that is a completion.
                if (ram_ready) begin
                    state_d = SETTLE;
                end else if (!d_req_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DGRANT;
                end
            end
            IGRANT: begin
                if (ram_ready) begin
                    state_d = SETTLE;
                end else if (!iREN) begin
                    state_d = IDLE;
                end else begin
                    state_d = IGRANT;
                end
            end
            SETTLE: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                streak_d = 4'd0;
            end
        endcase
    end

    // State and streak registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            streak_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    // RAM port routing and wait generation for the granted requester.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (state_q)
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dwait    = ~ram_ready;
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                iwait   = ~ram_ready;
            end
            IDLE: begin
                ramREN = 1'b0;
            end
            SETTLE: begin
                ramREN = 1'b0;
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

    assign iload = ramload;
    assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_ready;

    int n_vec = 0;
    int n_err = 0;

    mem_arbiter #(.ISTARVE_MAX(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_ready(ram_ready)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_idle_like(input string tag);
        check_eq({tag, ".ramREN"}, 32'(ramREN), 32'd0);
        check_eq({tag, ".ramWEN"}, 32'(ramWEN), 32'd0);
        check_eq({tag, ".iwait"}, 32'(iwait), 32'd1);
        check_eq({tag, ".dwait"}, 32'(dwait), 32'd1);
    endtask

    // Both requesters held with ram_ready high: IDLE, GRANT, SETTLE repeating.
    task automatic run_contest(input int n_cycles, input int g_base);
        logic exp_d;
        for (int i = 0; i < n_cycles; i++) begin
            #1;
            if ((i % 3) == 1) begin
                exp_d = (((g_base + i / 3) % 5) != 4);
                check_eq($sformatf("grant%0d.ramWEN", g_base + i / 3), 32'(ramWEN), 32'(exp_d));
                check_eq($sformatf("grant%0d.ramREN", g_base + i / 3), 32'(ramREN), 32'(!exp_d));
                check_eq($sformatf("grant%0d.iwait", g_base + i / 3), 32'(iwait), 32'(exp_d));
                check_eq($sformatf("grant%0d.dwait", g_base + i / 3), 32'(dwait), 32'(!exp_d));
            end else begin
                check_idle_like($sformatf("contest_c%0d", g_base * 3 + i));
            end
            tick();
        end
    endtask

    initial begin
        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0;
        iaddr = 32'hDEAD0000; daddr = 32'hBEEF0000; dstore = 32'hCAFEF00D; ramload = 32'h0;
        tick();
        tick();
        RST = 1'b0;
        #1;
        check_idle_like("reset");
        check_eq("reset.ramaddr", ramaddr, 32'd0);
        check_eq("reset.ramstore", ramstore, 32'd0);

        // Single fetch: ready two cycles after the grant.
        iREN = 1'b1; iaddr = 32'h40; ramload = 32'h12345678;
        #1;
        check_eq("fetch.idle.ramREN", 32'(ramREN), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            if (c == 2) ram_ready = 1'b1;
            #1;
            check_eq($sformatf("fetch.c%0d.ramREN", c), 32'(ramREN), 32'd1);
            check_eq($sformatf("fetch.c%0d.ramaddr", c), ramaddr, 32'h40);
            check_eq($sformatf("fetch.c%0d.iwait", c), 32'(iwait), (c == 2) ? 32'd0 : 32'd1);
            check_eq($sformatf("fetch.c%0d.dwait", c), 32'(dwait), 32'd1);
        end
        check_eq("fetch.iload", iload, 32'h12345678);
        check_eq("fetch.dload", dload, 32'h12345678);
        tick(); ram_ready = 1'b0; #1;
        check_idle_like("fetch.settle");
        tick(); iREN = 1'b0; #1;
        check_idle_like("fetch.idle");

        // Priority: icache and dcache write arrive together, streak 0.
        tick();
        iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h3100; dstore = 32'hBAD1BAD1;
        #1;
        check_idle_like("prio.idle");
        tick(); ram_ready = 1'b1; #1;
        check_eq("prio.d.ramWEN", 32'(ramWEN), 32'd1);
        check_eq("prio.d.ramREN", 32'(ramREN), 32'd0);
        check_eq("prio.d.ramaddr", ramaddr, 32'h3100);
        check_eq("prio.d.ramstore", ramstore, 32'hBAD1BAD1);
        check_eq("prio.d.dwait", 32'(dwait), 32'd0);
        check_eq("prio.d.iwait", 32'(iwait), 32'd1);
        tick(); ram_ready = 1'b0; dWEN = 1'b0; #1;
        check_idle_like("prio.settle");
        tick(); #1;
        check_idle_like("prio.idle2");
        tick(); ram_ready = 1'b1; #1;
        check_eq("prio.i.ramREN", 32'(ramREN), 32'd1);
        check_eq("prio.i.ramaddr", ramaddr, 32'h44);
        check_eq("prio.i.iwait", 32'(iwait), 32'd0);
        tick(); iREN = 1'b0; ram_ready = 1'b0;
        tick();

        // Read+write conflict: the write wins.
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'h55AA55AA;
        tick(); ram_ready = 1'b1; #1;
        check_eq("rw.ramWEN", 32'(ramWEN), 32'd1);
        check_eq("rw.ramREN", 32'(ramREN), 32'd0);
        check_eq("rw.ramstore", ramstore, 32'h55AA55AA);
        tick(); dREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0;
        tick();
        dREN = 1'b1; daddr = 32'h204; ramload = 32'hA5A5_0001;
        tick(); ram_ready = 1'b1; #1;
        check_eq("rd.ramREN", 32'(ramREN), 32'd1);
        check_eq("rd.ramWEN", 32'(ramWEN), 32'd0);
        check_eq("rd.ramaddr", ramaddr, 32'h204);
        check_eq("rd.dload", dload, 32'hA5A5_0001);
        check_eq("rd.dwait", 32'(dwait), 32'd0);
        tick(); dREN = 1'b0; ram_ready = 1'b0;
        tick();

        // Abort: dREN drops in the 2nd DGRANT cycle with ram_ready low.
        dREN = 1'b1; daddr = 32'h300;
        tick(); #1;
        check_eq("abort.c1.ramREN", 32'(ramREN), 32'd1);
        check_eq("abort.c1.dwait", 32'(dwait), 32'd1);
        tick(); dREN = 1'b0; #1;
        check_eq("abort.c2.ramREN", 32'(ramREN), 32'd0);
        check_eq("abort.c2.ramWEN", 32'(ramWEN), 32'd0);
        check_eq("abort.c2.dwait", 32'(dwait), 32'd1);
        tick(); dREN = 1'b1; #1;
        check_idle_like("abort.next");
        tick(); #1;
        check_eq("abort.regrant.ramREN", 32'(ramREN), 32'd1);
        // Ready and drop together is a completion, followed by SETTLE.
        dREN = 1'b0; ram_ready = 1'b1; #1;
        check_eq("done_drop.dwait", 32'(dwait), 32'd0);
        tick(); dREN = 1'b1; ram_ready = 1'b0; #1;
        check_idle_like("done_drop.settle");
        tick(); #1;
        check_idle_like("done_drop.idle");
        dREN = 1'b0;
        tick();

        // Starvation guard: both held, ready tied high.
        iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h900; dstore = 32'h0F0F0F0F;
        ram_ready = 1'b1;
        run_contest(30, 0);
        run_contest(12, 10);

        // Streak is now at the limit; enter IGRANT with ready low and reset mid-grant.
        ram_ready = 1'b0;
        tick(); #1;
        check_eq("rst.ig.ramREN", 32'(ramREN), 32'd1);
        check_eq("rst.ig.ramaddr", ramaddr, 32'h80);
        check_eq("rst.ig.iwait", 32'(iwait), 32'd1);
        tick(); RST = 1'b1;
        tick(); RST = 1'b0; #1;
        check_idle_like("rst.idle");
        check_eq("rst.idle.ramaddr", ramaddr, 32'd0);
        tick(); ram_ready = 1'b1; #1;
        check_eq("rst.after.ramWEN", 32'(ramWEN), 32'd1);
        check_eq("rst.after.ramREN", 32'(ramREN), 32'd0);
        check_eq("rst.after.ramaddr", ramaddr, 32'h900);
        check_eq("rst.after.dwait", 32'(dwait), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
